// File: rtl/frontend_pipe_regs_pkg.sv
// Shared types and constants for the front-end pipeline registers:
// the canonical NOP, the decoded-control bundle and its bubble value.
package frontend_pipe_regs_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic       reg_write;
      logic [1:0] result_src;
      logic       mem_write;
      logic       jump;
      logic       branch;
      logic [3:0] alu_ctrl;
      logic       alu_src;
   } de_ctrl_t;

   localparam de_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/frontend_pipe_regs_pipe_reg.sv
// Generic pipeline register: synchronous reset and clear both load RST_VAL,
// clear outranks enable, and enable low holds the current contents.
module frontend_pipe_regs_pipe_reg #(
   parameter int           W       = 32,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= RST_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/frontend_pipe_regs.sv
// PC register plus IF/ID and ID/EX pipeline registers, driven by the hazard
// unit's stall/flush controls, with stall and flush event counters.
module frontend_pipe_regs
   import frontend_pipe_regs_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_f,
   input  logic             stall_d,
   input  logic             flush,
   input  logic [XLEN-1:0]  pc_next,
   input  logic [31:0]      instr_f,
   input  logic [XLEN-1:0]  pc_plus4_f,
   output logic [XLEN-1:0]  pc_f,
   output logic [31:0]      instr_d,
   output logic [XLEN-1:0]  pc_d,
   output logic [XLEN-1:0]  pc_plus4_d,
   output logic             valid_d,
   input  de_ctrl_t         ctrl_d,
   input  logic [XLEN-1:0]  rd1_d,
   input  logic [XLEN-1:0]  rd2_d,
   input  logic [XLEN-1:0]  imm_ext_d,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rd_d,
   output de_ctrl_t         ctrl_e,
   output logic [XLEN-1:0]  rd1_e,
   output logic [XLEN-1:0]  rd2_e,
   output logic [XLEN-1:0]  imm_ext_e,
   output logic [XLEN-1:0]  pc_e,
   output logic [XLEN-1:0]  pc_plus4_e,
   output logic [4:0]       rs1_e,
   output logic [4:0]       rs2_e,
   output logic [4:0]       rd_e,
   output logic             valid_e,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int IFID_W = 32 + 2 * XLEN + 1;
   localparam int IDEX_W = $bits(de_ctrl_t) + 5 * XLEN + 15 + 1;
   localparam logic [IFID_W-1:0] IFID_RST = {NOP_INSTR, {(2 * XLEN + 1){1'b0}}};
   localparam logic [IDEX_W-1:0] IDEX_RST = {CTRL_BUBBLE, {(IDEX_W - $bits(de_ctrl_t)){1'b0}}};

   logic [IFID_W-1:0] ifid_d, ifid_q;
   logic [IDEX_W-1:0] idex_d, idex_q;

   // Fetch: PC register; flush redirects via pc_next, so only stall_f holds it.
   frontend_pipe_regs_pipe_reg #(.W(XLEN), .RST_VAL(RESET_PC[XLEN-1:0])) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (!stall_f),
      .clr (1'b0),
      .d   (pc_next),
      .q   (pc_f)
   );

   // IF/ID: squash on flush (wins over stall), hold on stall_d.
   assign ifid_d = {instr_f, pc_f, pc_plus4_f, 1'b1};
   assign {instr_d, pc_d, pc_plus4_d, valid_d} = ifid_q;

   frontend_pipe_regs_pipe_reg #(.W(IFID_W), .RST_VAL(IFID_RST)) u_ifid (
      .clk (clk),
      .rst (rst),
      .en  (!stall_d),
      .clr (flush),
      .d   (ifid_d),
      .q   (ifid_q)
   );

   // ID/EX: a bubble zeroes rd_e too, so a stalled slot never looks forwardable.
   assign idex_d = {ctrl_d, rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d,
                    rs1_d, rs2_d, rd_d, valid_d};
   assign {ctrl_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e,
           rs1_e, rs2_e, rd_e, valid_e} = idex_q;

   frontend_pipe_regs_pipe_reg #(.W(IDEX_W), .RST_VAL(IDEX_RST)) u_idex (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .clr (flush || stall_d),
      .d   (idex_d),
      .q   (idex_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_d) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush)   flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_frontend_pipe_regs.sv
// Scoreboard bench for frontend_pipe_regs: directed cycles push hand-computed
// post-edge state into a queue, a negedge monitor pops and compares it.
module tb_frontend_pipe_regs;
   import frontend_pipe_regs_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam logic [10:0] CTRL_A = 11'h5B3;
   localparam logic [31:0] RD1_V  = 32'hAAAA_0001;

   logic clk = 1'b0;
   logic rst, stall_f, stall_d, flush;
   logic [XLEN-1:0] pc_next, pc_plus4_f, pc_f, pc_d, pc_plus4_d;
   logic [31:0] instr_f, instr_d;
   logic valid_d, valid_e;
   de_ctrl_t ctrl_d, ctrl_e;
   logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d;
   logic [XLEN-1:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
   logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   always #5 clk = ~clk;

   // Stand-in for fetch adder and decoder feeding the registers.
   assign pc_plus4_f = pc_f + 32'd4;
   assign ctrl_d     = de_ctrl_t'(CTRL_A);
   assign rd1_d      = RD1_V;
   assign rd2_d      = 32'hBBBB_0002;
   assign imm_ext_d  = 32'h0000_0010;
   assign rs1_d      = instr_d[19:15];
   assign rs2_d      = instr_d[24:20];
   assign rd_d       = instr_d[11:7];

   frontend_pipe_regs #(.XLEN(XLEN), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush(flush),
      .pc_next(pc_next), .instr_f(instr_f), .pc_plus4_f(pc_plus4_f),
      .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
      .valid_d(valid_d), .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
      .imm_ext_d(imm_ext_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
      .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .valid_e(valid_e), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      string       tag;
      logic [31:0] pc_f, instr_d, pc_d, pc_e;
      logic        valid_d, valid_e, load_e;
      logic [4:0]  rd_e;
      logic [3:0]  scnt, fcnt;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", tag, name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.tag, "pc_f",      pc_f,                    e.pc_f);
         chk(e.tag, "instr_d",   instr_d,                 e.instr_d);
         chk(e.tag, "pc_d",      pc_d,                    e.pc_d);
         chk(e.tag, "valid_d",   32'(valid_d),            32'(e.valid_d));
         chk(e.tag, "ctrl_e",    32'(ctrl_e),             e.load_e ? 32'(CTRL_A) : 32'h0);
         chk(e.tag, "rd1_e",     rd1_e,                   e.load_e ? RD1_V : 32'h0);
         chk(e.tag, "rd_e",      32'(rd_e),               32'(e.rd_e));
         chk(e.tag, "pc_e",      pc_e,                    e.pc_e);
         chk(e.tag, "valid_e",   32'(valid_e),            32'(e.valid_e));
         chk(e.tag, "stall_cnt", 32'(stall_cnt),          32'(e.scnt));
         chk(e.tag, "flush_cnt", 32'(flush_cnt),          32'(e.fcnt));
      end
   end

   // Drive one cycle, then queue the state expected after that edge.
   task automatic step(input string tag, input logic r, sf, sd, fl,
                       input logic [31:0] pcn, ifi,
                       input logic [31:0] e_pcf, e_instr, e_pcd, input logic e_vd,
                       input logic e_load, input logic [4:0] e_rd,
                       input logic [31:0] e_pce, input logic e_ve,
                       input logic [3:0] e_s, e_f);
      exp_t e;
      rst = r; stall_f = sf; stall_d = sd; flush = fl;
      pc_next = pcn; instr_f = ifi;
      @(posedge clk);
      e.tag = tag; e.pc_f = e_pcf; e.instr_d = e_instr; e.pc_d = e_pcd;
      e.valid_d = e_vd; e.load_e = e_load; e.rd_e = e_rd; e.pc_e = e_pce;
      e.valid_e = e_ve; e.scnt = e_s; e.fcnt = e_f;
      exp_q.push_back(e);
      #1;
   endtask

   localparam logic [31:0] I0 = 32'h0010_0113; // rd=2
   localparam logic [31:0] I1 = 32'h00A0_0093; // rd=1
   localparam logic [31:0] I2 = 32'h0010_81B3; // rd=3
   localparam logic [31:0] I3 = 32'h0000_0213; // rd=4
   localparam logic [31:0] I4 = 32'h0050_0293; // rd=5
   localparam logic [31:0] I5 = 32'h0060_0313; // rd=6
   localparam logic [31:0] I6 = 32'h0070_0393; // rd=7
   localparam logic [31:0] I7 = 32'h0080_0413; // rd=8
   localparam logic [31:0] NOP = 32'h0000_0013;

   initial begin
      int wait_cycles;
      rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush = 1'b0;
      pc_next = '0; instr_f = '0;
      //          tag       r  sf sd fl pcn     instr  pc_f    instr_d pc_d   vd ld rd pc_e   ve s  f
      step("rst0",      1, 0, 0, 0, 32'h0,  I0,  32'h0,  NOP, 32'h0,  0, 0, 0, 32'h0,  0, 0, 0);
      step("rst1",      1, 0, 0, 0, 32'h0,  I0,  32'h0,  NOP, 32'h0,  0, 0, 0, 32'h0,  0, 0, 0);
      step("seq0",      0, 0, 0, 0, 32'h4,  I0,  32'h4,  I0,  32'h0,  1, 1, 0, 32'h0,  0, 0, 0);
      step("seq1",      0, 0, 0, 0, 32'h8,  I1,  32'h8,  I1,  32'h4,  1, 1, 2, 32'h0,  1, 0, 0);
      step("stall",     0, 1, 1, 0, 32'hC,  I2,  32'h8,  I1,  32'h4,  1, 0, 0, 32'h0,  0, 1, 0);
      step("unstall",   0, 0, 0, 0, 32'hC,  I2,  32'hC,  I2,  32'h8,  1, 1, 1, 32'h4,  1, 1, 0);
      step("flush",     0, 0, 0, 1, 32'h40, I3,  32'h40, NOP, 32'h0,  0, 0, 0, 32'h0,  0, 1, 1);
      step("tgt0",      0, 0, 0, 0, 32'h44, I4,  32'h44, I4,  32'h40, 1, 1, 0, 32'h0,  0, 1, 1);
      step("tgt1",      0, 0, 0, 0, 32'h48, I5,  32'h48, I5,  32'h44, 1, 1, 5, 32'h40, 1, 1, 1);
      step("flush_stl", 0, 0, 1, 1, 32'h80, I6,  32'h80, NOP, 32'h0,  0, 0, 0, 32'h0,  0, 2, 2);
      step("sf_only",   0, 1, 0, 0, 32'h84, I7,  32'h80, I7,  32'h80, 1, 1, 0, 32'h0,  0, 2, 2);
      step("recapt",    0, 0, 0, 0, 32'h84, I7,  32'h84, I7,  32'h80, 1, 1, 8, 32'h80, 1, 2, 2);
      step("run0",      0, 1, 1, 0, 32'h88, I0,  32'h84, I7,  32'h80, 1, 0, 0, 32'h0,  0, 3, 2);
      step("run1",      0, 1, 1, 0, 32'h88, I0,  32'h84, I7,  32'h80, 1, 0, 0, 32'h0,  0, 4, 2);
      step("run2",      0, 1, 1, 0, 32'h88, I0,  32'h84, I7,  32'h80, 1, 0, 0, 32'h0,  0, 5, 2);
      step("rst_mid",   1, 1, 1, 1, 32'h88, I0,  32'h0,  NOP, 32'h0,  0, 0, 0, 32'h0,  0, 0, 0);
      step("post_rst",  0, 0, 0, 0, 32'h4,  I0,  32'h4,  I0,  32'h0,  1, 1, 0, 32'h0,  0, 0, 0);
      for (int k = 1; k <= 17; k++) begin
         step($sformatf("wrap%0d", k), 0, 1, 1, 0, 32'h8, I1,
              32'h4, I0, 32'h0, 1, 0, 0, 32'h0, 0, 4'(k % 16), 0);
      end
      stall_f = 1'b0; stall_d = 1'b0; flush = 1'b0;
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      @(posedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
